// File: rtl/mkio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mkio_pkg                                                                   |
// | Shared types and defaults for the mkio Manchester II receive path.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mkio_pkg;

  // Encoded as {DI1, DI0} so the synchronized pair casts straight to a level.
  typedef enum logic [1:0] {
    LINE_INVALID_LO = 2'b00,
    LINE_ZERO       = 2'b01,
    LINE_ONE        = 2'b10,
    LINE_INVALID_HI = 2'b11
  } line_lvl_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'b00,
    RX_SYNC2 = 2'b01,
    RX_DATA  = 2'b10,
    RX_DONE  = 2'b11
  } rx_state_e;

  localparam logic SYNC_CMD     = 1'b1;
  localparam int   HALF_BIT_DEF = 16;
  localparam int   SYNC_MIN_DEF = 40;

  function automatic logic lvl_is_valid(input line_lvl_e l);
    return (l == LINE_ZERO) || (l == LINE_ONE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mkio_rx_line_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mkio_rx_line_filter                                                        |
// | Two-flop synchronizer for DI1/DI0, optional 3-sample majority filter       |
// | (MKIO_RX_GLITCH_FILTER_EN), and decode to a line level.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mkio_rx_line_filter
  import mkio_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      di1,
  input  logic      di0,
  output line_lvl_e level
);

  logic [1:0] meta_q, meta_d;
  logic [1:0] sync_q, sync_d;
  logic [1:0] lines;

  always_comb begin
    meta_d = {di1, di0};
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 2'b00;
      sync_q <= 2'b00;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

`ifdef MKIO_RX_GLITCH_FILTER_EN
  logic [1:0] hist1_q, hist1_d;
  logic [1:0] hist2_q, hist2_d;

  always_comb begin
    hist1_d = sync_q;
    hist2_d = hist1_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist1_q <= 2'b00;
      hist2_q <= 2'b00;
    end else begin
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
    end
  end

  // Bitwise majority of the last three samples: a step passes one clock late.
  assign lines = (sync_q & hist1_q) | (sync_q & hist2_q) | (hist1_q & hist2_q);
`else
  assign lines = sync_q;
`endif

  assign level = line_lvl_e'(lines);

endmodule
`default_nettype wire

// File: rtl/mkio_man_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mkio_man_rx                                                                |
// | MIL-STD-1553B Manchester II word receiver: sync detect, 16 data bits plus |
// | odd parity, one-clock rx_valid strobe. Glitch filter: MKIO_RX_GLITCH_FILTER_EN.
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mkio_man_rx
  import mkio_pkg::*;
#(
  parameter int HALF_BIT = HALF_BIT_DEF,
  parameter int SYNC_MIN = SYNC_MIN_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_en,
  input  logic        di1,
  input  logic        di0,
  output logic [15:0] rx_data,
  output logic        rx_sync,
  output logic        rx_valid,
  output logic        rx_par_err,
  output logic        rx_man_err,
  output logic        rx_busy
);

  localparam int                PH_W       = $clog2(3 * HALF_BIT);
  localparam logic [PH_W-1:0]   PH_CHK     = PH_W'(HALF_BIT + HALF_BIT / 2);
  localparam logic [PH_W-1:0]   PH_SYNC_END = PH_W'(3 * HALF_BIT - 1);
  localparam logic [PH_W-1:0]   PH_BIT_END = PH_W'(2 * HALF_BIT - 1);
  localparam logic [PH_W-1:0]   PH_FIRST   = PH_W'(HALF_BIT / 2);
  localparam logic [PH_W-1:0]   PH_SECOND  = PH_W'(HALF_BIT + HALF_BIT / 2);
  localparam logic [7:0]        RUN_MIN    = 8'(SYNC_MIN - 1);
  localparam logic [4:0]        LAST_BIT   = 5'd16;

  line_lvl_e        level;
  rx_state_e        state_q, state_d;
  line_lvl_e        prev_q, prev_d;
  line_lvl_e        first_q, first_d;
  logic [7:0]       run_q, run_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [4:0]       bit_q, bit_d;
  logic [15:0]      shift_q, shift_d;
  logic             man_q, man_d;
  logic             pol_q, pol_d;
  logic [15:0]      data_q, data_d;
  logic             sync_out_q, sync_out_d;
  logic             par_q, par_d;
  logic             man_out_q, man_out_d;

  logic             sync_hit, sync_chk, sync_end, samp1, samp2, last;
  logic             bit_val, bit_err;
  line_lvl_e        post_lvl;

  mkio_rx_line_filter u_line (
    .clk   (clk),
    .reset (reset),
    .di1   (di1),
    .di0   (di0),
    .level (level)
  );

  // run_q is one less than the length of the run that just ended.
  assign sync_hit = lvl_is_valid(level) && lvl_is_valid(prev_q) &&
                    (level != prev_q) && (run_q >= RUN_MIN);
  assign post_lvl = (pol_q == SYNC_CMD) ? LINE_ZERO : LINE_ONE;
  assign sync_chk = (state_q == RX_SYNC2) && (ph_q == PH_CHK);
  assign sync_end = (state_q == RX_SYNC2) && (ph_q == PH_SYNC_END);
  assign samp1    = (state_q == RX_DATA) && (ph_q == PH_FIRST);
  assign samp2    = (state_q == RX_DATA) && (ph_q == PH_SECOND);
  assign last     = samp2 && (bit_q == LAST_BIT);
  assign bit_val  = (first_q == LINE_ONE);
  assign bit_err  = !(((first_q == LINE_ONE) && (level == LINE_ZERO)) ||
                      ((first_q == LINE_ZERO) && (level == LINE_ONE)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RX_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!rx_en) begin
      state_d = RX_IDLE;
    end else begin
      case (state_q)
        RX_IDLE:  if (sync_hit) state_d = RX_SYNC2;
        RX_SYNC2: begin
          if (sync_chk && (level != post_lvl)) state_d = RX_IDLE;
          else if (sync_end)                   state_d = RX_DATA;
        end
        RX_DATA:  if (last) state_d = RX_DONE;
        RX_DONE:  state_d = RX_IDLE;
        default:  state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_valid = rx_en && (state_q == RX_DONE);
    rx_busy  = rx_en && (state_q != RX_IDLE);
  end

  always_comb begin
    prev_d     = level;
    run_d      = (level != prev_q) ? 8'd0 : ((run_q == 8'hFF) ? run_q : run_q + 8'd1);
    ph_d       = '0;
    bit_d      = bit_q;
    first_d    = first_q;
    shift_d    = shift_q;
    man_d      = man_q;
    pol_d      = pol_q;
    data_d     = data_q;
    sync_out_d = sync_out_q;
    par_d      = par_q;
    man_out_d  = man_out_q;
    case (state_q)
      RX_IDLE: begin
        if (sync_hit) begin
          ph_d  = PH_W'(1);
          bit_d = 5'd0;
          man_d = 1'b0;
          pol_d = (prev_q == LINE_ONE) ? SYNC_CMD : ~SYNC_CMD;
        end
      end
      RX_SYNC2: ph_d = sync_end ? '0 : ph_q + 1'b1;
      RX_DATA: begin
        ph_d = (ph_q == PH_BIT_END) ? '0 : ph_q + 1'b1;
        if (samp1) first_d = level;
        if (samp2) begin
          man_d = man_q | bit_err;
          if (bit_q != LAST_BIT) begin
            shift_d = {shift_q[14:0], bit_val};
            bit_d   = bit_q + 5'd1;
          end
        end
      end
      default: ;
    endcase
    // The parity bit is live here, so the word is published straight from the shifter.
    if (last && rx_en) begin
      data_d     = shift_q;
      sync_out_d = pol_q;
      par_d      = ~(^{shift_q, bit_val});
      man_out_d  = man_q | bit_err;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q     <= LINE_INVALID_LO;
      first_q    <= LINE_INVALID_LO;
      run_q      <= 8'd0;
      ph_q       <= '0;
      bit_q      <= 5'd0;
      shift_q    <= 16'd0;
      man_q      <= 1'b0;
      pol_q      <= 1'b0;
      data_q     <= 16'd0;
      sync_out_q <= 1'b0;
      par_q      <= 1'b0;
      man_out_q  <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      first_q    <= first_d;
      run_q      <= run_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      man_q      <= man_d;
      pol_q      <= pol_d;
      data_q     <= data_d;
      sync_out_q <= sync_out_d;
      par_q      <= par_d;
      man_out_q  <= man_out_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_sync    = sync_out_q;
  assign rx_par_err = par_q;
  assign rx_man_err = man_out_q;

endmodule
`default_nettype wire

// File: tb/tb_mkio_man_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mkio_man_rx                                                             |
// | Self-checking bench: bus waveforms built per clock from a word model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mkio_man_rx;

  localparam int H = 16;
`ifdef MKIO_RX_GLITCH_FILTER_EN
  localparam int LAT = 588;
`else
  localparam int LAT = 587;
`endif
  localparam logic [1:0] LV_LO = 2'b00, LV_ZERO = 2'b01, LV_ONE = 2'b10, LV_HI = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_en = 1'b0;
  logic        di1 = 1'b0;
  logic        di0 = 1'b0;
  logic [15:0] rx_data;
  logic        rx_sync, rx_valid, rx_par_err, rx_man_err, rx_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt = 0;

  logic [1:0]  wave[$];
  logic [15:0] exp_data[$];
  logic        exp_sync[$], exp_par[$], exp_man[$];
  int          exp_mid[$];
  logic [15:0] got_data[$];
  logic        got_sync[$], got_par[$], got_man[$];
  int          got_cyc[$];

  mkio_man_rx #(.HALF_BIT(H), .SYNC_MIN(40)) dut (
    .clk(clk), .reset(reset), .rx_en(rx_en), .di1(di1), .di0(di0),
    .rx_data(rx_data), .rx_sync(rx_sync), .rx_valid(rx_valid),
    .rx_par_err(rx_par_err), .rx_man_err(rx_man_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_busy) busy_cnt <= busy_cnt + 1;
    if (rx_valid) begin
      got_data.push_back(rx_data);
      got_sync.push_back(rx_sync);
      got_par.push_back(rx_par_err);
      got_man.push_back(rx_man_err);
      got_cyc.push_back(cyc);
    end
  end

  task automatic add_level(input logic [1:0] lv, input int n);
    for (int i = 0; i < n; i++) wave.push_back(lv);
  endtask

  // Appends sync + 17 bits; bit err_bit (if >= 0) is forced to err_f/err_s halves.
  task automatic add_word(input logic cmd, input logic [15:0] data, input logic par_flip,
                          input int err_bit, input logic [1:0] err_f, input logic [1:0] err_s,
                          output int mid);
    logic [16:0] bits;
    logic [1:0]  f, s;
    logic [15:0] dw;
    logic        d, man;
    int          ones;
    bits = {data, (~^data) ^ par_flip};
    add_level(cmd ? LV_ONE : LV_ZERO, 3 * H);
    mid = wave.size();
    add_level(cmd ? LV_ZERO : LV_ONE, 3 * H);
    ones = 0; dw = 16'd0; man = 1'b0;
    for (int k = 0; k < 17; k++) begin
      f = bits[16-k] ? LV_ONE : LV_ZERO;
      s = bits[16-k] ? LV_ZERO : LV_ONE;
      if (k == err_bit) begin f = err_f; s = err_s; end
      add_level(f, H);
      add_level(s, H);
      if (f == LV_ONE && s == LV_ZERO)      d = 1'b1;
      else if (f == LV_ZERO && s == LV_ONE) d = 1'b0;
      else begin d = (f == LV_ONE); man = 1'b1; end
      ones += int'(d);
      if (k < 16) dw = {dw[14:0], d};
    end
    exp_data.push_back(dw);
    exp_sync.push_back(cmd);
    exp_par.push_back((ones % 2) == 0);
    exp_man.push_back(man);
    exp_mid.push_back(mid);
  endtask

  // Drives n waveform entries (all if n <= 0), one per clock; base = cycle of entry 0.
  task automatic play(input int n, output int base);
    int cnt;
    cnt = (n <= 0) ? wave.size() : n;
    base = 0;
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk); #1;
      if (i == 0) base = cyc;
      {di1, di0} = wave.pop_front();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; rx_en = 1'b1; {di1, di0} = LV_LO;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rx_data !== 16'd0) begin errors++; $display("FAIL reset_data got %h want 0000", rx_data); end
    checks++;
    if ({rx_sync, rx_valid, rx_par_err, rx_man_err, rx_busy} !== 5'd0) begin
      errors++; $display("FAIL reset_flags got %b want 00000", {rx_sync, rx_valid, rx_par_err, rx_man_err, rx_busy});
    end
    @(posedge clk); #1 reset = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", rx_busy); end
  endtask

  task automatic test_command();
    int mid, base, n0, b0;
    n0 = got_data.size(); b0 = busy_cnt;
    add_word(1'b1, 16'h0847, 1'b0, -1, LV_LO, LV_LO, mid);
    add_level(LV_LO, 40);
    play(0, base);
    @(negedge clk);
    checks++;
    if (got_data.size() - n0 != 1) begin errors++; $display("FAIL cmd_count got %0d want 1", got_data.size() - n0); end
    if (got_data.size() > n0) begin
      checks++;
      if (got_data[n0] !== 16'h0847) begin errors++; $display("FAIL cmd_data got %h want 0847", got_data[n0]); end
      checks++;
      if ({got_sync[n0], got_par[n0], got_man[n0]} !== 3'b100) begin
        errors++; $display("FAIL cmd_flags sync/par/man got %b want 100", {got_sync[n0], got_par[n0], got_man[n0]});
      end
      checks++;
      if (got_cyc[n0] != base + mid + LAT) begin errors++; $display("FAIL cmd_latency got %0d want %0d", got_cyc[n0] - base - mid, LAT); end
    end
    checks++;
    if (busy_cnt - b0 != 585) begin errors++; $display("FAIL cmd_busy_cycles got %0d want 585", busy_cnt - b0); end
    repeat (50) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rx_data, rx_sync, rx_valid} !== {16'h0847, 1'b1, 1'b0}) begin
      errors++; $display("FAIL cmd_hold got %h/%b/%b want 0847/1/0", rx_data, rx_sync, rx_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words[7] = '{16'h1234, 16'hFFFF, 16'h0000, 16'hA5A5, 16'h8001, 16'h7FFE, 16'h5A5A};
    int mid, base, n0, e0;
    n0 = got_data.size(); e0 = exp_data.size();
    foreach (words[i]) add_word(1'b0, words[i], 1'b0, -1, LV_LO, LV_LO, mid);
    add_level(LV_LO, 40);
    play(0, base);
    @(negedge clk);
    checks++;
    if (got_data.size() - n0 != 7) begin errors++; $display("FAIL b2b_count got %0d want 7", got_data.size() - n0); end
    for (int i = 0; i < 7 && n0 + i < got_data.size(); i++) begin
      checks++;
      if ({got_data[n0+i], got_sync[n0+i], got_par[n0+i], got_man[n0+i]} !== {words[i], 3'b000}) begin
        errors++; $display("FAIL b2b_word%0d got %h/%b%b%b want %h/000", i, got_data[n0+i],
                           got_sync[n0+i], got_par[n0+i], got_man[n0+i], words[i]);
      end
      checks++;
      if (got_cyc[n0+i] != base + exp_mid[e0+i] + LAT) begin
        errors++; $display("FAIL b2b_time%0d got %0d want %0d", i, got_cyc[n0+i], base + exp_mid[e0+i] + LAT);
      end
      if (i > 0) begin
        checks++;
        if (got_cyc[n0+i] - got_cyc[n0+i-1] != 640) begin
          errors++; $display("FAIL b2b_spacing%0d got %0d want 640", i, got_cyc[n0+i] - got_cyc[n0+i-1]);
        end
      end
    end
  endtask

  task automatic test_parity();
    int mid, base, n0;
    n0 = got_data.size();
    add_word(1'b1, 16'h0847, 1'b1, -1, LV_LO, LV_LO, mid);
    add_level(LV_LO, 40);
    play(0, base);
    @(negedge clk);
    checks++;
    if (got_data.size() - n0 != 1) begin errors++; $display("FAIL par_count got %0d want 1", got_data.size() - n0); end
    if (got_data.size() > n0) begin
      checks++;
      if ({got_data[n0], got_sync[n0], got_par[n0], got_man[n0]} !== {16'h0847, 3'b110}) begin
        errors++; $display("FAIL par_word got %h/%b%b%b want 0847/110", got_data[n0], got_sync[n0], got_par[n0], got_man[n0]);
      end
    end
  endtask

  task automatic test_man_err();
    int mid, base, n0;
    n0 = got_data.size();
    add_word(1'b0, 16'h00FF, 1'b0, 5, LV_HI, LV_HI, mid);
    add_level(LV_LO, 40);
    play(0, base);
    @(negedge clk);
    checks++;
    if (got_data.size() - n0 != 1) begin errors++; $display("FAIL man_count got %0d want 1", got_data.size() - n0); end
    if (got_data.size() > n0) begin
      checks++;
      if ({got_data[n0], got_sync[n0], got_par[n0], got_man[n0]} !== {16'h00FF, 3'b001}) begin
        errors++; $display("FAIL man_word got %h/%b%b%b want 00ff/001", got_data[n0], got_sync[n0], got_par[n0], got_man[n0]);
      end
      checks++;
      if (got_cyc[n0] != base + mid + LAT) begin errors++; $display("FAIL man_time got %0d want %0d", got_cyc[n0], base + mid + LAT); end
    end
  endtask

  task automatic test_reset_mid_word();
    int mid, base, n0;
    n0 = got_data.size();
    add_word(1'b0, 16'hC3C3, 1'b0, -1, LV_LO, LV_LO, mid);
    add_level(LV_LO, 40);
    play(360, base);
    reset = 1'b0;
    #1;
    checks++;
    if ({rx_data, rx_sync, rx_valid, rx_par_err, rx_man_err, rx_busy} !== 21'd0) begin
      errors++; $display("FAIL midrst_outputs got %h want 000000", {rx_data, rx_sync, rx_valid, rx_par_err, rx_man_err, rx_busy});
    end
    @(posedge clk); #1 reset = 1'b1;
    play(0, base);
    @(negedge clk);
    checks++;
    if (got_data.size() != n0) begin errors++; $display("FAIL midrst_strobe got %0d want 0", got_data.size() - n0); end
    n0 = got_data.size();
    add_word(1'b0, 16'h1234, 1'b0, -1, LV_LO, LV_LO, mid);
    add_level(LV_LO, 40);
    play(0, base);
    @(negedge clk);
    checks++;
    if (got_data.size() - n0 != 1) begin errors++; $display("FAIL midrst_next_count got %0d want 1", got_data.size() - n0); end
    if (got_data.size() > n0) begin
      checks++;
      if ({got_data[n0], got_par[n0], got_man[n0]} !== {16'h1234, 2'b00}) begin
        errors++; $display("FAIL midrst_next got %h/%b%b want 1234/00", got_data[n0], got_par[n0], got_man[n0]);
      end
    end
  endtask

  task automatic test_rx_en();
    int mid, base, n0, b0;
    n0 = got_data.size(); b0 = busy_cnt;
    rx_en = 1'b0;
    add_word(1'b1, 16'hBEEF, 1'b0, -1, LV_LO, LV_LO, mid);
    add_level(LV_LO, 40);
    play(0, base);
    @(negedge clk);
    checks++;
    if (got_data.size() != n0) begin errors++; $display("FAIL rxen_strobe got %0d want 0", got_data.size() - n0); end
    checks++;
    if (busy_cnt != b0) begin errors++; $display("FAIL rxen_busy got %0d want 0", busy_cnt - b0); end
    rx_en = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_false_sync();
    int base, n0;
    n0 = got_data.size();
    add_level(LV_ONE, 3 * H);
    add_level(LV_ZERO, 20);
    add_level(LV_LO, 700);
    play(0, base);
    @(negedge clk);
    checks++;
    if (got_data.size() != n0) begin errors++; $display("FAIL falsesync_strobe got %0d want 0", got_data.size() - n0); end
  endtask

  task automatic test_glitch();
    int mid, base, n0;
    logic [15:0] want_d;
    logic [1:0]  want_pm;
`ifdef MKIO_RX_GLITCH_FILTER_EN
    want_d = 16'h1234; want_pm = 2'b00;
`else
    want_d = 16'h0234; want_pm = 2'b11;
`endif
    n0 = got_data.size();
    add_word(1'b0, 16'h1234, 1'b0, -1, LV_LO, LV_LO, mid);
    add_level(LV_LO, 40);
    wave[mid + 152] = ~wave[mid + 152];
    play(0, base);
    @(negedge clk);
    checks++;
    if (got_data.size() - n0 != 1) begin errors++; $display("FAIL glitch_count got %0d want 1", got_data.size() - n0); end
    if (got_data.size() > n0) begin
      checks++;
      if ({got_data[n0], got_par[n0], got_man[n0]} !== {want_d, want_pm}) begin
        errors++; $display("FAIL glitch_word got %h/%b%b want %h/%b", got_data[n0], got_par[n0], got_man[n0], want_d, want_pm);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] ef[5] = '{LV_LO, LV_HI, LV_ONE, LV_ZERO, LV_HI};
    logic [1:0] es[5] = '{LV_LO, LV_HI, LV_ONE, LV_ZERO, LV_ZERO};
    int mid, base, n0, e0, eb, et;
    n0 = got_data.size(); e0 = exp_data.size();
    for (int w = 0; w < 6; w++) begin
      if ($urandom_range(0, 1) == 1) add_level(LV_LO, $urandom_range(8, 40));
      eb = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : -1;
      et = $urandom_range(0, 4);
      add_word(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) == 0),
               eb, ef[et], es[et], mid);
    end
    add_level(LV_LO, 40);
    play(0, base);
    @(negedge clk);
    checks++;
    if (got_data.size() - n0 != 6) begin errors++; $display("FAIL rand_count got %0d want 6", got_data.size() - n0); end
    for (int i = 0; i < 6 && n0 + i < got_data.size(); i++) begin
      checks++;
      if ({got_data[n0+i], got_sync[n0+i], got_par[n0+i], got_man[n0+i]} !==
          {exp_data[e0+i], exp_sync[e0+i], exp_par[e0+i], exp_man[e0+i]}) begin
        errors++; $display("FAIL rand_word%0d got %h/%b%b%b want %h/%b%b%b", i, got_data[n0+i], got_sync[n0+i],
                           got_par[n0+i], got_man[n0+i], exp_data[e0+i], exp_sync[e0+i], exp_par[e0+i], exp_man[e0+i]);
      end
      checks++;
      if (got_cyc[n0+i] != base + exp_mid[e0+i] + LAT) begin
        errors++; $display("FAIL rand_time%0d got %0d want %0d", i, got_cyc[n0+i], base + exp_mid[e0+i] + LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_command();
    test_back_to_back();
    test_parity();
    test_man_err();
    test_reset_mid_word();
    test_rx_en();
    test_false_sync();
    test_glitch();
    test_random();
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
